// File: rtl/fifo_pkt_pkg.sv
// fifo_pkt_pkg: types and constants shared by the packet FIFO writer and reader
package fifo_pkt_pkg;
   localparam int PKT_DATA_WIDTH = 8;
   localparam int EOP_BIT = PKT_DATA_WIDTH;
   localparam int TRAILER_WORDS = 2;
   localparam int PKT_CNT_WIDTH = 16;
   typedef enum logic [1:0] {DATA, TRL_CNT, TRL_SUM} pkt_state_t;
endpackage

// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: streams packets into the FIFO write port and appends a count + XOR checksum trailer
module fifo_pkt_writer
   import fifo_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = PKT_DATA_WIDTH,
   localparam int FIFO_WIDTH = DATA_WIDTH + 1
) (
   input  logic                     wr_clk,
   input  logic                     wr_rstn,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [DATA_WIDTH-1:0]    s_data,
   input  logic                     s_last,
   output logic                     wr_en,
   output logic [FIFO_WIDTH-1:0]    wr_data,
   input  logic                     wr_full,
   output logic                     pkt_done,
   output logic [PKT_CNT_WIDTH-1:0] pkt_count
);
   pkt_state_t state;
   logic run;
   logic [DATA_WIDTH-1:0] beat_cnt;
   logic [DATA_WIDTH-1:0] csum;
   // Payload passes straight through; trailer words are written whenever the FIFO has room
   always_comb begin
      s_ready = run && !wr_full && state == DATA;
      wr_en   = run && !wr_full && (state != DATA || s_valid);
      wr_data = state == DATA ? {1'b0, s_data} : state == TRL_CNT ? {1'b0, beat_cnt} : {1'b1, csum};
   end
   always_ff @(posedge wr_clk or negedge wr_rstn)
      if (!wr_rstn) begin
         state     <= DATA;
         run       <= 1'b0;
         beat_cnt  <= '0;
         csum      <= '0;
         pkt_count <= '0;
         pkt_done  <= 1'b0;
      end else begin
         run      <= 1'b1;
         pkt_done <= 1'b0;
         if (wr_en)
            case (state)
               DATA: begin
                  beat_cnt <= beat_cnt + 1'b1;
                  csum     <= csum ^ s_data;
                  if (s_last) state <= TRL_CNT;
               end
               TRL_CNT: state <= TRL_SUM;
               default: begin
                  beat_cnt  <= '0;
                  csum      <= '0;
                  pkt_count <= pkt_count + 1'b1;
                  pkt_done  <= 1'b1;
                  state     <= DATA;
               end
            endcase
      end
endmodule
